arbitro_rr_salida: RTL
======================

// Module: arbitro_rr_salida
// PURPOSE
//  Output-side round-robin arbiter. Drains the four class FIFOs (FIFO_0..3_salida,
//  filled by the input-side class arbiter) into one downstream FIFO, at most one
//  word per cycle. Stalls on downstream almost_full.
//  Keeps a 5-bit forwarded-word counter per class, readable on request.
// PARAMETERS
//  DATA_SIZE  12  word width, identical to the FIFO data width
//  CNT_SIZE   5   width of each per-class counter (wraps)
// PORTS
//  clk             in   1          system clock, all state on rising edge
//  reset_L         in   1          asynchronous, active-low reset
//  fifo_empty      in   4          bit i = FIFO_i_salida empty
//  data_in0..3     in   DATA_SIZE  FIFO_i fifo_data_out
//  valid0..3       in   1          FIFO_i valid: data_in_i is valid one cycle after pop_i
//  out_almost_full in   1          downstream FIFO almost_full
//  pop0..3         out  1          read strobe to FIFO_i, at most one high per cycle
//  data_out        out  DATA_SIZE  word to downstream FIFO
//  push            out  1          write strobe to downstream FIFO
//  cont_req        in   1          counter read request
//  cont_sel        in   2          class counter to read
//  cont_out        out  CNT_SIZE   requested counter value
//  cont_valid      out  1          cont_out valid strobe
//  idle            out  1          no eligible FIFO and nothing in flight
// BEHAVIOUR
//  Reset (reset_L=0, async):
//   - pop*, push, data_out, cont_out, cont_valid = 0; idle = 1.
//   - rr_ptr = 0; counters = 0; pipeline regs cleared; state = IDLE.
//   - A reset mid-transfer discards in-flight words. No push follows the reset.
//  FSM, 2 states, registered:
//   - IDLE->ACTIVE when (|~fifo_empty) & ~out_almost_full.
//   - ACTIVE->IDLE when (&fifo_empty) | out_almost_full.
//  Grant (combinational from the current state and inputs):
//   - In ACTIVE, the arbiter scans i = rr_ptr, rr_ptr+1, ... (mod 4) and grants the
//     first non-empty FIFO.
//   - In IDLE, and in any cycle where out_almost_full=1, no pop is issued.
//   - A grant raises pop_g. The pop may be issued in the same cycle the FSM leaves IDLE.
//     The eligibility test is the same as the ACTIVE test.
//   - After a grant to g: rr_ptr <= g+1 (mod 4). With no grant, rr_ptr holds.
//   - An empty FIFO is never popped.
//   - Back-to-back pops to the same FIFO are allowed when it is the only non-empty one.
//  Data path, fixed latency 2:
//   - Cycle N: pop_g=1. Regs sel_d1<=g, pend_d1<=1.
//   - Cycle N+1: the FIFO drives valid_g/data_in_g. On the edge,
//     data_out <= data_in_{sel_d1}, and push <= pend_d1 & valid_{sel_d1}.
//   - Cycle N+2: push=1 with the word.
//   - If valid_g is missing in N+1, no push occurs and data_out holds.
//   - Words from one FIFO leave in FIFO order. Class interleave follows the grant order.
//  Backpressure:
//   - Up to 2 words can be in flight when almost_full rises. These words are still pushed.
//   - The downstream almost_full threshold must leave >=2 free slots.
//  Counters:
//   - On each push from class sel_d2, cnt[sel_d2] += 1, wrapping 31->0.
//   - cont_req=1 in cycle N: cont_out=cnt[cont_sel] and cont_valid=1 in N+1.
//     cont_out is sampled before any increment from the same edge.
//   - Otherwise cont_valid=0 and cont_out holds.
//  idle = (state==IDLE) & ~pend_d1 & ~push.
// TESTING
//  1 Reset, then reset_L=0 mid-burst -> all outputs 0 and idle=1 immediately.
//    No push after release until a new pop.
//  2 Only FIFO2 holds 0xA01,0xA02,0xA03 -> pop2 high 3 consecutive cycles.
//    push high cycles N+2..N+4 with data 0xA01,0xA02,0xA03.
//  3 FIFO0..3 each hold one word 0x100,0x201,0x302,0x403, rr_ptr=0 ->
//    pop order 0,1,2,3, push data in the same order, rr_ptr ends at 0.
//  4 As in 2, with out_almost_full=1 in the second pop cycle ->
//    pop2 drops that cycle and 1 word is pushed.
//    Release -> the remaining 2 words follow, none lost or duplicated.
//  5 After test 3, cont_req=1 with cont_sel=2 -> next cycle cont_valid=1, cont_out=1.
//    Push 32 words from FIFO1, then read -> cont_out=1 (wrapped).
//  6 FIFO1 and FIFO3 refilled continuously -> grants alternate 1,3,1,3.
//    FIFO0/2 are never popped.

Source files
------------

// File: rtl/arbitro_rr_salida.sv
// arbitro_rr_salida: output-side round-robin arbiter.
// Drains four class FIFOs into one downstream FIFO, one word per cycle at most.
// The read path has a fixed two-cycle latency: pop -> FIFO valid -> push.
// Each class has a wrapping counter of forwarded words that can be read on request.
module arbitro_rr_salida #(
  parameter int DATA_SIZE = 12,
  parameter int CNT_SIZE  = 5
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [3:0]           fifo_empty,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic [DATA_SIZE-1:0] data_in1,
  input  logic [DATA_SIZE-1:0] data_in2,
  input  logic [DATA_SIZE-1:0] data_in3,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 valid2,
  input  logic                 valid3,
  input  logic                 out_almost_full,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 pop2,
  output logic                 pop3,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 push,
  input  logic                 cont_req,
  input  logic [1:0]           cont_sel,
  output logic [CNT_SIZE-1:0]  cont_out,
  output logic                 cont_valid,
  output logic                 idle
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   rr_ptr_q, rr_ptr_d;

  // Request scan / grant
  logic [3:0]                   req;
  logic [3:0]                   pop_vec;
  logic                         grant_vld;
  logic [1:0]                   grant_idx;
  logic [1:0]                   scan_idx;

  // Two-stage read pipeline
  logic                         pend_d1_q;
  logic [1:0]                   sel_d1_q;
  logic [1:0]                   sel_d2_q;
  logic                         push_q;
  logic [DATA_SIZE-1:0]         data_out_q;
  logic [DATA_SIZE-1:0]         sel_data;
  logic                         sel_valid;
  logic                         fwd_word;

  // Per-class counters and readout
  logic [3:0][CNT_SIZE-1:0]     cnt_q;
  logic [CNT_SIZE-1:0]          cont_out_q;
  logic                         cont_valid_q;

  assign req = ~fifo_empty;

  // Round-robin scan starting at rr_ptr; the first non-empty FIFO wins.
  // Pop eligibility (some FIFO non-empty, no almost_full) is exactly the
  // IDLE->ACTIVE condition, so a grant in IDLE only ever happens on the
  // leaving cycle and the state itself need not gate the scan.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    pop_vec   = '0;
    if (reset_L && !out_almost_full) begin
      for (int unsigned k = 0; k < 4; k++) begin
        scan_idx = rr_ptr_q + 2'(k);
        if (!grant_vld && req[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) begin
      pop_vec[grant_idx] = 1'b1;
    end
  end

  assign pop0 = pop_vec[0];
  assign pop1 = pop_vec[1];
  assign pop2 = pop_vec[2];
  assign pop3 = pop_vec[3];

  // Next-state logic for the FSM and the round-robin pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if ((|req) && !out_almost_full) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if ((&fifo_empty) || out_almost_full) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_vld) begin
      rr_ptr_d = grant_idx + 2'd1;
    end
  end

  // FSM state and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Select the data/valid of the FIFO popped in the previous cycle.
  always_comb begin
    sel_data  = data_in0;
    sel_valid = valid0;
    unique case (sel_d1_q)
      2'd0: begin sel_data = data_in0; sel_valid = valid0; end
      2'd1: begin sel_data = data_in1; sel_valid = valid1; end
      2'd2: begin sel_data = data_in2; sel_valid = valid2; end
      2'd3: begin sel_data = data_in3; sel_valid = valid3; end
      default: begin sel_data = data_in0; sel_valid = valid0; end
    endcase
  end

  assign fwd_word = pend_d1_q & sel_valid;

  // Read pipeline: remember the grant, then capture the FIFO word when valid.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pend_d1_q  <= 1'b0;
      sel_d1_q   <= '0;
      sel_d2_q   <= '0;
      push_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      pend_d1_q <= grant_vld;
      if (grant_vld) begin
        sel_d1_q <= grant_idx;
      end
      push_q <= fwd_word;
      if (fwd_word) begin
        data_out_q <= sel_data;
        sel_d2_q   <= sel_d1_q;
      end
    end
  end

  // Forwarded-word counters and readout; readout sees the pre-increment value.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q        <= '0;
      cont_out_q   <= '0;
      cont_valid_q <= 1'b0;
    end else begin
      if (push_q) begin
        cnt_q[sel_d2_q] <= cnt_q[sel_d2_q] + 1'b1;
      end
      cont_valid_q <= cont_req;
      if (cont_req) begin
        cont_out_q <= cnt_q[cont_sel];
      end
    end
  end

  assign data_out   = data_out_q;
  assign push       = push_q;
  assign cont_out   = cont_out_q;
  assign cont_valid = cont_valid_q;
  assign idle       = (state_q == IDLE) & ~pend_d1_q & ~push_q;

endmodule
